// File: rtl/tk1_spi_target.sv
// tk1_spi_target: mode-0 SPI target (8-bit frames, MSB first, SS active low),
// oversampling SCK/SS/MOSI in the clk domain.
// Latency: a synchronised SPI edge acts SYNC_STAGES+1 clk cycles after it occurs.
// Backpressure: none toward the master; an unacked rx byte sets overrun, an empty tx buffer sends IDLE_BYTE and sets underrun.
//
// Ports:
//   clk, reset_n            system clock, synchronous active-low reset
//   spi_ss/sck/mosi         SPI inputs from the master (asynchronous to clk)
//   spi_miso, spi_miso_oe   target-out data and its output enable
//   rx_data/rx_valid/rx_ack received byte, valid flag, consume pulse
//   tx_data/tx_data_we      transmit byte and its write strobe; tx_full = buffer occupied
//   overrun/underrun        sticky error flags, cleared by err_clear
//   active                  FSM is not idle
module tk1_spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hff
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_ss,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_data_we,
  output logic       tx_full,
  output logic       overrun,
  output logic       underrun,
  input  logic       err_clear,
  output logic       active
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ss_sync, sck_sync, mosi_sync;
  logic                   ss_hist, sck_hist;
  logic                   ss_s, sck_s, mosi_s;
  logic                   ss_fall, sck_rise, sck_fall;

  logic [2:0] bitcnt;
  logic [6:0] shift_rx;
  logic [7:0] shift_tx;
  logic [7:0] tx_buf;
  logic [7:0] rx_byte;
  logic       do_shift, load, byte_done, rx_accept, set_ovr, set_udr;

  // Synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ss_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_hist   <= 1'b1;
      sck_hist  <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      ss_hist   <= ss_sync[SYNC_STAGES-1];
      sck_hist  <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign ss_fall  = ss_hist & ~ss_s;
  assign sck_rise = ~sck_hist & sck_s;
  assign sck_fall = sck_hist & ~sck_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: deselect returns to IDLE from any state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ss_fall) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = ss_s ? S_IDLE : S_SHIFT;
      S_SHIFT: if (ss_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    spi_miso    = 1'b1;
    spi_miso_oe = 1'b0;
    active      = (state != S_IDLE);
    if (state == S_SHIFT) begin
      spi_miso    = shift_tx[7];
      spi_miso_oe = 1'b1;
    end
  end

  // Shifting is suppressed once the synchronised select has gone high, so the
  // edge that ends a frame never touches the datapath.
  assign do_shift  = (state == S_SHIFT) && !ss_s;
  // A falling SCK with bitcnt==0 in SHIFT follows a completed byte: reload.
  assign load      = ((state == S_LOAD) && !ss_s) || (do_shift && sck_fall && (bitcnt == 3'd0));
  assign rx_byte   = {shift_rx, mosi_s};
  assign byte_done = do_shift && sck_rise && (bitcnt == 3'd7);
  assign rx_accept = byte_done && (!rx_valid || rx_ack);
  assign set_ovr   = byte_done && rx_valid && !rx_ack;
  assign set_udr   = load && !tx_full;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bitcnt   <= 3'd0;
      shift_rx <= 7'd0;
      shift_tx <= 8'd0;
      tx_buf   <= 8'd0;
      tx_full  <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (!do_shift) begin
        bitcnt <= 3'd0;
      end else if (sck_rise) begin
        bitcnt   <= bitcnt + 3'd1;
        shift_rx <= rx_byte[6:0];
      end

      if (load)                     shift_tx <= tx_full ? tx_buf : IDLE_BYTE;
      else if (do_shift && sck_fall) shift_tx <= {shift_tx[6:0], 1'b0};

      // A write in the load cycle: the load used the old buffer, the new byte stays.
      if (tx_data_we) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end else if (load && tx_full) begin
        tx_full <= 1'b0;
      end

      if (rx_accept) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end

      overrun  <= set_ovr | (overrun & ~err_clear);
      underrun <= set_udr | (underrun & ~err_clear);
    end
  end

endmodule

// File: tb/tb_tk1_spi_target.sv
// tb_tk1_spi_target: directed self-checking bench for tk1_spi_target.
// A behavioural mode-0 master drives SCK at clk/16; inputs change and outputs
// are sampled on the falling clk edge.
module tb_tk1_spi_target;

  localparam int SYNC = 2;
  localparam int HALF = 8;  // clk cycles per SCK half period

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_ss = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_data_we = 1'b0;
  logic       tx_full, overrun, underrun;
  logic       err_clear = 1'b0;
  logic       active;

  int total = 0;
  int bad = 0;
  logic [7:0]  mi;
  logic [14:0] rst_vec;

  always #5 clk = ~clk;

  tk1_spi_target #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hff)) dut (
    .clk(clk), .reset_n(reset_n), .spi_ss(spi_ss), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_data_we(tx_data_we), .tx_full(tx_full),
    .overrun(overrun), .underrun(underrun), .err_clear(err_clear), .active(active)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_data = d; tx_data_we = 1'b1; tick(1); tx_data_we = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1; tick(1); rx_ack = 1'b0;
  endtask

  task automatic clear_err();
    err_clear = 1'b1; tick(1); err_clear = 1'b0;
  endtask

  // Shifts one byte; returns right after the 8th rising SCK edge (SCK left high).
  task automatic shift_byte(input logic [7:0] mo, output logic [7:0] m_in);
    for (int i = 7; i >= 0; i--) begin
      spi_sck = 1'b0; spi_mosi = mo[i]; tick(HALF);
      m_in[i] = spi_miso; spi_sck = 1'b1;
      if (i != 0) tick(HALF);
    end
  endtask

  task automatic end_frame();
    tick(HALF - SYNC - 2); spi_sck = 1'b0; tick(HALF); spi_ss = 1'b1; tick(8);
  endtask

  // {spi_miso, oe, rx_valid, tx_full, overrun, underrun, active, rx_data}
  function automatic logic [14:0] out_vec();
    return {spi_miso, spi_miso_oe, rx_valid, tx_full, overrun, underrun, active, rx_data};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; tick(3);
    rst_vec = out_vec(); total++;
    if (rst_vec !== 15'b1_0_0_0_0_0_0_00000000) begin
      bad++; $display("FAIL reset_outputs got=%b want=%b", rst_vec, 15'b100000000000000);
    end
    reset_n = 1'b1; tick(3);
    total++;
    if (active !== 1'b0) begin bad++; $display("FAIL reset_idle active=%b want=0", active); end
  endtask

  task automatic test_single_byte();
    write_tx(8'hA5);
    spi_ss = 1'b0;
    shift_byte(8'h3C, mi);
    tick(SYNC + 2);
    total++; if (mi !== 8'hA5) begin bad++; $display("FAIL single_miso got=%h want=a5", mi); end
    total++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
      bad++; $display("FAIL single_rx got v=%b d=%h want v=1 d=3c", rx_valid, rx_data); end
    total++; if (tx_full !== 1'b0 || underrun !== 1'b0) begin
      bad++; $display("FAIL single_flags got full=%b udr=%b want 0 0", tx_full, underrun); end
    end_frame();
    pulse_ack(); clear_err();
  endtask

  task automatic test_underrun();
    spi_ss = 1'b0;
    shift_byte(8'h00, mi);
    tick(SYNC + 2);
    total++; if (mi !== 8'hFF) begin bad++; $display("FAIL underrun_miso got=%h want=ff", mi); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set got=%b want=1", underrun); end
    end_frame();
    clear_err(); tick(1);
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_clear got=%b want=0", underrun); end
    pulse_ack();
  endtask

  task automatic test_overrun();
    spi_ss = 1'b0;
    shift_byte(8'h11, mi); tick(SYNC + 2);
    total++; if (rx_data !== 8'h11 || overrun !== 1'b0) begin
      bad++; $display("FAIL overrun_first got d=%h ovr=%b want d=11 ovr=0", rx_data, overrun); end
    tick(HALF - SYNC - 2);
    shift_byte(8'h22, mi); tick(SYNC + 2);
    total++; if (rx_data !== 8'h11 || overrun !== 1'b1) begin
      bad++; $display("FAIL overrun_second got d=%h ovr=%b want d=11 ovr=1", rx_data, overrun); end
    tick(HALF - SYNC - 2);
    // ack lands exactly on the completion cycle of the third byte
    shift_byte(8'h33, mi); tick(SYNC); rx_ack = 1'b1; tick(1); rx_ack = 1'b0; tick(1);
    total++; if (rx_data !== 8'h33 || rx_valid !== 1'b1) begin
      bad++; $display("FAIL overrun_ack_same_cycle got d=%h v=%b want d=33 v=1", rx_data, rx_valid); end
    end_frame();
    pulse_ack(); clear_err();
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi2;
    write_tx(8'h81);
    spi_ss = 1'b0;
    shift_byte(8'hC3, mi); tick(SYNC + 2);
    total++; if (rx_data !== 8'hC3 || rx_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_rx0 got d=%h v=%b want d=c3 v=1", rx_data, rx_valid); end
    pulse_ack(); write_tx(8'h7E);
    tick(HALF - SYNC - 4);
    shift_byte(8'h5A, mi2); tick(SYNC + 2);
    total++; if (mi !== 8'h81 || mi2 !== 8'h7E) begin
      bad++; $display("FAIL b2b_miso got %h %h want 81 7e", mi, mi2); end
    total++; if (rx_data !== 8'h5A || rx_valid !== 1'b1 || underrun !== 1'b0) begin
      bad++; $display("FAIL b2b_rx1 got d=%h v=%b udr=%b want d=5a v=1 udr=0", rx_data, rx_valid, underrun); end
    end_frame();
    pulse_ack(); clear_err();
  endtask

  task automatic test_abort();
    spi_ss = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spi_sck = 1'b0; spi_mosi = 1'b1; tick(HALF);
      spi_sck = 1'b1; tick(HALF);
    end
    spi_sck = 1'b0; tick(HALF); spi_ss = 1'b1; tick(8);
    total++; if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL abort_no_rx got v=%b ovr=%b want 0 0", rx_valid, overrun); end
    total++; if (active !== 1'b0 || spi_miso_oe !== 1'b0) begin
      bad++; $display("FAIL abort_idle got act=%b oe=%b want 0 0", active, spi_miso_oe); end
    spi_ss = 1'b0;
    shift_byte(8'h96, mi); tick(SYNC + 2);
    total++; if (rx_data !== 8'h96 || rx_valid !== 1'b1) begin
      bad++; $display("FAIL abort_next_byte got d=%h v=%b want d=96 v=1", rx_data, rx_valid); end
    end_frame();
    clear_err();
  endtask

  task automatic test_reset_mid();
    write_tx(8'h3C);
    spi_ss = 1'b0;
    for (int i = 0; i < 3; i++) begin
      spi_sck = 1'b0; spi_mosi = i[0]; tick(HALF);
      spi_sck = 1'b1; tick(HALF);
    end
    spi_sck = 1'b0; tick(2);
    reset_n = 1'b0; spi_ss = 1'b1; tick(3);
    rst_vec = out_vec(); total++;
    if (rst_vec !== 15'b1_0_0_0_0_0_0_00000000) begin
      bad++; $display("FAIL midreset_outputs got=%b want=%b", rst_vec, 15'b100000000000000);
    end
    reset_n = 1'b1; tick(4);
    write_tx(8'h5C);
    spi_ss = 1'b0;
    shift_byte(8'hA3, mi); tick(SYNC + 2);
    total++; if (mi !== 8'h5C || rx_data !== 8'hA3 || rx_valid !== 1'b1) begin
      bad++; $display("FAIL midreset_next got miso=%h d=%h v=%b want 5c a3 1", mi, rx_data, rx_valid); end
    end_frame();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_underrun();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tk1_spi_target.md
Name: tk1_spi_target

Overview:
- SPI target (slave) endpoint: the receiving end of the tk1 SPI master protocol.
- Mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first, SS active low.
- Oversamples SCK, SS and MOSI in the clk domain; presents received bytes and accepts transmit bytes over a simple valid/ack and write-strobe interface.
- Used as an on-chip loopback and verification target for the SPI master and as an auxiliary-device interface.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on spi_ss, spi_sck and spi_mosi (legal values 2 or 3).
- IDLE_BYTE, 8'hff: byte shifted out when no transmit byte is buffered.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- spi_ss  in  1  target select, active low.
- spi_sck  in  1  SPI clock from the master.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  target-out data.
- spi_miso_oe  out  1  MISO output enable; 1 while selected.
- rx_data  out  8  last accepted received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ack  in  1  consume pulse; clears rx_valid.
- tx_data  in  8  byte to transmit.
- tx_data_we  in  1  write strobe for tx_data.
- tx_full  out  1  transmit buffer occupied.
- overrun  out  1  sticky: a byte completed while rx_valid=1 without ack.
- underrun  out  1  sticky: IDLE_BYTE was sent because tx buffer was empty.
- err_clear  in  1  clears overrun and underrun.
- active  out  1  synchronised select state (FSM not in IDLE).

Behaviour:
- Reset:
  - Synchronous, active-low reset_n on clk.
  - All outputs 0 except spi_miso=1 and rx_data=8'h00.
  - Synchronisers preset to ss=1, sck=0, mosi=0.
  - FSM in IDLE; bit counter 0.
- Synchronisation:
  - Each input passes through SYNC_STAGES flops.
  - Edges are detected from the last stage versus one extra history flop.
  - Edge-to-action latency is SYNC_STAGES+1 clk cycles.
- SCK rate limit: SCK frequency ≤ clk/8. Faster SCK is unsupported and not detected.
- FSM states:
  - IDLE:
    - spi_miso_oe=0, spi_miso=1.
    - SS falling edge -> LOAD.
  - LOAD (one cycle):
    - If tx_full: shift_tx <= tx buffer, tx_full <= 0.
    - Else: shift_tx <= IDLE_BYTE, underrun <= 1.
    - bitcnt <= 0; go to SHIFT.
  - SHIFT:
    - spi_miso_oe=1; spi_miso = shift_tx[7].
    - SCK rising: shift_rx <= {shift_rx[6:0], mosi}; bitcnt++ (3-bit, wraps 7->0).
    - On the rising edge where bitcnt was 7, the byte completes:
      - If rx_valid=0 or rx_ack is high that cycle: rx_data <= assembled byte, rx_valid <= 1.
      - Otherwise: rx_data is unchanged and overrun <= 1.
    - SCK falling:
      - If bitcnt==0 (byte boundary after a completed byte): reload shift_tx using the LOAD rules.
      - Else: shift_tx <= shift_tx << 1.
    - SS rising edge (synchronised ss=1), from any state: go to IDLE.
      - A partial byte is discarded with no rx_valid and no overrun.
      - bitcnt is cleared.
- Handshake rules:
  - rx_ack with rx_valid=0 is a no-op.
  - rx_ack in the same cycle as a byte completion: the new byte is accepted and rx_valid stays 1.
- Transmit buffer rules:
  - tx_data_we always writes the buffer and sets tx_full; a write while full overwrites.
  - A write in the same cycle as a load:
    - The load uses the pre-cycle buffer state.
    - The written byte remains buffered afterwards with tx_full=1.
- Error flags:
  - err_clear clears both flags.
  - A set event in the same cycle as err_clear takes priority: the flag ends 1.
- Reset mid-transfer: immediate return to IDLE; all state cleared per the reset values.

Test Plan:
- Single-byte receive: tx_data=8'hA5 written; SS low; master shifts 8'h3C.
  -> MISO bits 1,0,1,0,0,1,0,1.
  -> rx_valid=1, rx_data=8'h3C within SYNC_STAGES+2 clk of the 8th SCK rising edge.
  -> tx_full=0; underrun=0.
- Underrun: no tx write; SS low; master shifts 8'h00.
  -> MISO 8'hFF sequence; underrun=1.
  -> err_clear pulse -> underrun=0.
- Overrun: two bytes 8'h11, 8'h22 with no rx_ack.
  -> rx_data=8'h11, overrun=1.
  -> rx_ack on the completion cycle of a third byte 8'h33 -> rx_data=8'h33, rx_valid=1.
- Back-to-back bytes: tx 8'h81 buffered, then 8'h7E written during the first byte.
  -> MISO streams 8'h81 then 8'h7E without gap.
  -> rx bytes 8'hC3, 8'h5A each acked and received correctly.
- Abort: SS rises after 5 SCK edges.
  -> no rx_valid; active=0; spi_miso_oe=0.
  -> next full byte 8'h96 is received correctly (bitcnt restarted).
- Reset mid-transfer: reset_n low during bit 3.
  -> all outputs at reset values; FSM in IDLE; next transfer works normally.
